// File: rtl/branch_predictor_btb_if.sv
// Fetch/resolve-side bundle for the branch predictor: lookup request and
// prediction, resolved-branch update, global flush and mispredict statistics.
interface branch_predictor_btb_if #(
    parameter int ADDRESS_LEN = 12,
    parameter int STAT_BITS   = 16
);
    logic [ADDRESS_LEN-1:0] lookup_pc;
    logic                   pred_hit;
    logic                   pred_taken;
    logic [ADDRESS_LEN-1:0] pred_target;
    logic                   upd_en;
    logic [ADDRESS_LEN-1:0] upd_pc;
    logic                   upd_taken;
    logic [ADDRESS_LEN-1:0] upd_target;
    logic                   upd_mispredict;
    logic                   flush_all;
    logic [STAT_BITS-1:0]   misp_cnt;

    // Pipeline side: drives lookups and resolved branches, consumes predictions.
    modport master (
        output lookup_pc, upd_en, upd_pc, upd_taken, upd_target, upd_mispredict, flush_all,
        input  pred_hit, pred_taken, pred_target, misp_cnt
    );

    // Predictor side.
    modport slave (
        input  lookup_pc, upd_en, upd_pc, upd_taken, upd_target, upd_mispredict, flush_all,
        output pred_hit, pred_taken, pred_target, misp_cnt
    );
endinterface

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with per-entry saturating direction
// counters. Lookup is combinational (feeds the IF next-PC mux); updates from
// the resolve stage land on the clock edge with no bypass to the lookup path.
module branch_predictor_btb #(
    parameter int ADDRESS_LEN = 12,
    parameter int IDX_BITS    = 4,
    parameter int CTR_BITS    = 2,
    parameter int STAT_BITS   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    branch_predictor_btb_if.slave   bus
);
    localparam int ENTRIES  = 2 ** IDX_BITS;
    localparam int TAG_BITS = ADDRESS_LEN - IDX_BITS;

    // Counter encodings: MSB set means "predict taken".
    localparam logic [CTR_BITS-1:0] CTR_MAX     = '1;
    localparam logic [CTR_BITS-1:0] CTR_WEAK_T  = CTR_BITS'(1 << (CTR_BITS - 1));
    localparam logic [CTR_BITS-1:0] CTR_WEAK_NT = CTR_WEAK_T - 1'b1;

    logic                   entry_valid  [ENTRIES];
    logic [TAG_BITS-1:0]    entry_tag    [ENTRIES];
    logic [ADDRESS_LEN-1:0] entry_target [ENTRIES];
    logic [CTR_BITS-1:0]    entry_ctr    [ENTRIES];

    logic [IDX_BITS-1:0]    lk_idx;
    logic [TAG_BITS-1:0]    lk_tag;
    logic                   lk_hit;
    logic                   lk_taken;
    logic [IDX_BITS-1:0]    upd_idx;
    logic [TAG_BITS-1:0]    upd_tag;
    logic                   upd_hit;
    logic [STAT_BITS-1:0]   misp_cnt_reg;

    // Lookup path: reads the current (pre-update) entry state.
    assign lk_idx   = bus.lookup_pc[IDX_BITS-1:0];
    assign lk_tag   = bus.lookup_pc[ADDRESS_LEN-1:IDX_BITS];
    assign lk_hit   = entry_valid[lk_idx] && (entry_tag[lk_idx] == lk_tag);
    assign lk_taken = lk_hit && entry_ctr[lk_idx][CTR_BITS-1];

    assign bus.pred_hit    = lk_hit;
    assign bus.pred_taken  = lk_taken;
    // Fall-through address wraps naturally at ADDRESS_LEN bits.
    assign bus.pred_target = lk_taken ? entry_target[lk_idx] : bus.lookup_pc + 1'b1;

    // Update path: hit detection against the entry the resolved branch maps to.
    assign upd_idx = bus.upd_pc[IDX_BITS-1:0];
    assign upd_tag = bus.upd_pc[ADDRESS_LEN-1:IDX_BITS];
    assign upd_hit = entry_valid[upd_idx] && (entry_tag[upd_idx] == upd_tag);

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : gen_entry
            logic                   valid_reg;
            logic [TAG_BITS-1:0]    tag_reg;
            logic [ADDRESS_LEN-1:0] target_reg;
            logic [CTR_BITS-1:0]    ctr_reg;
            logic                   sel;

            assign sel = bus.upd_en && (upd_idx == IDX_BITS'(gi));

            // Entry state: flush only clears valid; hit trains, taken miss allocates.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    valid_reg  <= 1'b0;
                    tag_reg    <= '0;
                    target_reg <= '0;
                    ctr_reg    <= CTR_WEAK_NT;
                end else if (bus.flush_all) begin
                    valid_reg <= 1'b0;
                end else if (sel) begin
                    if (upd_hit) begin
                        if (bus.upd_taken) begin
                            if (ctr_reg != CTR_MAX) begin
                                ctr_reg <= ctr_reg + 1'b1;
                            end
                            target_reg <= bus.upd_target;
                        end else if (ctr_reg != '0) begin
                            ctr_reg <= ctr_reg - 1'b1;
                        end
                    end else if (bus.upd_taken) begin
                        valid_reg  <= 1'b1;
                        tag_reg    <= upd_tag;
                        target_reg <= bus.upd_target;
                        ctr_reg    <= CTR_WEAK_T;
                    end
                end
            end

            assign entry_valid[gi]  = valid_reg;
            assign entry_tag[gi]    = tag_reg;
            assign entry_target[gi] = target_reg;
            assign entry_ctr[gi]    = ctr_reg;
        end
    endgenerate

    // Mispredict statistics: saturating, independent of flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misp_cnt_reg <= '0;
        end else if (bus.upd_en && bus.upd_mispredict && (misp_cnt_reg != '1)) begin
            misp_cnt_reg <= misp_cnt_reg + 1'b1;
        end
    end

    assign bus.misp_cnt = misp_cnt_reg;

endmodule
